// File: rtl/fp_pkg.sv
// Shared types for the floating-point adder result and its fixed-point converter.
package fp_pkg;

  localparam int EXP_W = 4;
  localparam int MAN_W = 8;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2,
    ST_OUT   = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fp_to_fixed_seq.sv
// Converts {sign, exp, frac} to a saturated signed fixed-point word using a
// one-bit-per-cycle shifter, with valid/ready handshakes on both sides.
module fp_to_fixed_seq
  import fp_pkg::*;
#(
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_frac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  localparam logic signed [7:0] SH_OFS    = 8'(FRAC_BITS - MAN_W);
  localparam logic [OUT_W-1:0]  MAG_LIMIT = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]  ONE       = {{(OUT_W-1){1'b0}}, 1'b1};

  fp_word_t          in_word;
  logic signed [7:0] shamt;
  logic [7:0]        shamt_abs;
  logic [OUT_W:0]    sat_res;

  fsm_state_t        state_q;
  logic              sign_q;
  logic [OUT_W-1:0]  mag_q;
  logic [4:0]        cnt_q;
  logic              dir_left_q;
  logic              ovf_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              out_ovf_q;

  // Returns {ovf, data}; -2^(OUT_W-1) is representable, so only a larger negative magnitude saturates.
  function automatic logic [OUT_W:0] saturate(input logic sign, input logic [OUT_W-1:0] mag,
                                              input logic ovf_in);
    logic ovf;
    ovf = ovf_in | (~sign & mag[OUT_W-1]) | (sign & (mag > MAG_LIMIT));
    if (ovf) begin
      saturate = {1'b1, (sign ? MAG_LIMIT : ~MAG_LIMIT)};
    end else begin
      saturate = {1'b0, (sign ? (~mag + ONE) : mag)};
    end
  endfunction

  always_comb begin
    in_word   = '{sign: in_sign, exp: in_exp, frac: in_frac};
    shamt     = $signed({{(8-EXP_W){1'b0}}, in_word.exp}) + SH_OFS;
    shamt_abs = shamt[7] ? 8'(-shamt) : 8'(shamt);
    sat_res   = saturate(sign_q, mag_q, ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      cnt_q       <= 5'd0;
      dir_left_q  <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (in_valid) begin
            sign_q     <= in_word.sign;
            mag_q      <= {{(OUT_W-MAN_W){1'b0}}, in_word.frac};
            cnt_q      <= shamt_abs[4:0];
            dir_left_q <= ~shamt[7];
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= (shamt == 8'sd0) ? ST_FIN : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A set MSB before a left shift would be lost: saturate and stop early.
          if (dir_left_q && mag_q[OUT_W-1]) begin
            ovf_q   <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            mag_q <= dir_left_q ? (mag_q << 1) : (mag_q >> 1);
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
              state_q <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          out_data_q  <= sat_res[OUT_W-1:0];
          out_ovf_q   <= sat_res[OUT_W];
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule
